// File: rtl/load_port_arbiter_if.sv
// Request/grant memory bus with in-order rvalid responses, used for both
// the master-side ports and the shared L2 memory port of the arbiter.
interface load_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    lock;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_port_arbiter.sv
// Two-to-one arbiter sharing the L2 load/debug port between the SPI load path
// (m0) and the JTAG debug path (m1); routes in-order responses back by ID FIFO.
module load_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    load_port_arbiter_if.slave          m0,
    load_port_arbiter_if.slave          m1,
    load_port_arbiter_if.master         s,
    output logic [$clog2(MAX_OUTST):0]  outst_o,
    output logic                        err_o
);
    localparam int            PW   = $clog2(MAX_OUTST);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);

    logic                 en_q, en_d;
    logic                 rr_q, rr_d;
    logic                 hold_q, hold_d;
    logic                 hsel_q, hsel_d;
    logic                 lock_q, lock_d;
    logic                 lsel_q, lsel_d;
    logic [MAX_OUTST-1:0] fifo_q, fifo_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                    sel;
    logic                    sel_req;
    logic                    sel_lock;
    logic                    not_full;
    logic                    xfer;
    logic                    pop;
    logic                    head;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_we;
    logic [DATA_WIDTH/8-1:0] sel_be;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Until enabled the selection rests on m0 so the memory port sees m0's fields.
    always_comb begin
        sel = 1'b0;
        if (!en_q) begin
            sel = 1'b0;
        end else if (hold_q) begin
            sel = hsel_q;
        end else if (lock_q) begin
            sel = lsel_q;
        end else if (m0.req && m1.req) begin
            sel = rr_q;
        end else if (m1.req) begin
            sel = 1'b1;
        end
    end

    always_comb begin
        sel_req   = m0.req;
        sel_lock  = m0.lock;
        sel_addr  = m0.addr;
        sel_we    = m0.we;
        sel_be    = m0.be;
        sel_wdata = m0.wdata;
        if (sel) begin
            sel_req   = m1.req;
            sel_lock  = m1.lock;
            sel_addr  = m1.addr;
            sel_we    = m1.we;
            sel_be    = m1.be;
            sel_wdata = m1.wdata;
        end
    end

    assign not_full = (cnt_q < FULL);
    assign xfer     = s.req & s.gnt;
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = s.rvalid & (cnt_q != '0);

    assign s.req   = en_q & sel_req & not_full;
    assign s.addr  = sel_addr;
    assign s.we    = sel_we;
    assign s.be    = sel_be;
    assign s.wdata = sel_wdata;
    assign s.lock  = sel_lock;

    assign m0.gnt    = xfer & ~sel;
    assign m1.gnt    = xfer & sel;
    assign m0.rvalid = pop & ~head;
    assign m1.rvalid = pop & head;
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    assign outst_o = cnt_q;
    assign err_o   = err_q;

    always_comb begin
        en_d     = 1'b1;
        rr_d     = rr_q;
        hold_d   = hold_q;
        hsel_d   = hsel_q;
        lock_d   = lock_q;
        lsel_d   = lsel_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;

        if (xfer) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            rr_d             = ~sel;
            hold_d           = 1'b0;
            if (sel_lock) begin
                lock_d = 1'b1;
                lsel_d = sel;
            end else if (lock_q && (lsel_q == sel)) begin
                lock_d = 1'b0;
            end
        end else if (s.req) begin
            // Freeze the choice so the slave never sees the request change masters.
            hold_d = 1'b1;
            hsel_d = sel;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (s.rvalid) begin
            err_d = 1'b1;
        end

        cnt_d = cnt_q + CW'(xfer) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            rr_q     <= 1'b0;
            hold_q   <= 1'b0;
            hsel_q   <= 1'b0;
            lock_q   <= 1'b0;
            lsel_q   <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            hsel_q   <= hsel_d;
            lock_q   <= lock_d;
            lsel_q   <= lsel_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_load_port_arbiter.sv
// Bench for load_port_arbiter: per-cycle vector table with a response
// scoreboard, plus hand-written reset, error and full-FIFO sequences.
module tb_load_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam logic [31:0] A0 = 32'h0000_1104;
    localparam logic [31:0] A1 = 32'h0000_2208;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outst;
    logic       err;

    load_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    load_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    load_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    load_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .outst_o(outst),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         m0_req, m1_req, m0_lock, m1_lock, s_gnt;
        bit         e_sreq, e_g0, e_g1, e_asel;
        logic [2:0] e_outst;
    } vec_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] rq[$];
    bit          auto_resp = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t v(bit rst, bit r0, bit r1, bit l0, bit l1, bit g,
                               bit esr, bit eg0, bit eg1, bit eas, logic [2:0] eo);
        vec_t t;
        t.rst = rst; t.m0_req = r0; t.m1_req = r1; t.m0_lock = l0; t.m1_lock = l1;
        t.s_gnt = g; t.e_sreq = esr; t.e_g0 = eg0; t.e_g1 = eg1; t.e_asel = eas;
        t.e_outst = eo;
        return t;
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic exp_t mk(input bit id, input logic [31:0] d);
        exp_t e;
        e.id = id; e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One clock: score responses and capture grants mid-cycle, then drive the next response.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (s_if.rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            chk1("rsp_m0_rvalid", m0_if.rvalid, !e.id);
            chk1("rsp_m1_rvalid", m1_if.rvalid, e.id);
            chk("rsp_rdata", e.id ? m1_if.rdata : m0_if.rdata, e.data);
        end
        if (auto_resp && s_if.req && s_if.gnt) rq.push_back(mem_f(s_if.addr));
        @(posedge clk);
        #1;
        if (auto_resp) begin
            if (rq.size() > 0) begin
                s_if.rvalid = 1'b1;
                s_if.rdata  = rq.pop_front();
            end else begin
                s_if.rvalid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_if.rvalid = 1'b0;
        rq.delete();
        sb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        m0_if.req = 1'b0; m0_if.addr = A0; m0_if.we = 1'b0; m0_if.be = 4'hF;
        m0_if.wdata = 32'h1111_0000; m0_if.lock = 1'b0;
        m1_if.req = 1'b0; m1_if.addr = A1; m1_if.we = 1'b1; m1_if.be = 4'h3;
        m1_if.wdata = 32'h2222_0000; m1_if.lock = 1'b0;
        s_if.gnt = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;

        // Round-robin
        tbl.push_back(v(1, 1,1,0,0,1, 1,1,0,0, 3'd0));
        tbl.push_back(v(0, 1,1,0,0,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 1,1,0,0,1, 1,1,0,0, 3'd1));
        tbl.push_back(v(0, 1,1,0,0,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd0));
        // Hold under back-pressure (rr points at m1 once m0 has been served)
        tbl.push_back(v(1, 1,0,0,0,1, 1,1,0,0, 3'd0));
        tbl.push_back(v(0, 1,0,0,0,0, 1,0,0,0, 3'd1));
        tbl.push_back(v(0, 1,1,0,0,0, 1,0,0,0, 3'd0));
        tbl.push_back(v(0, 1,1,0,0,0, 1,0,0,0, 3'd0));
        tbl.push_back(v(0, 1,1,0,0,1, 1,1,0,0, 3'd0));
        tbl.push_back(v(0, 0,1,0,0,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd0));
        // Lock burst by m1, including a gap where the owner stops requesting
        tbl.push_back(v(1, 1,0,0,0,1, 1,1,0,0, 3'd0));
        tbl.push_back(v(0, 1,1,0,1,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 1,1,0,1,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 1,1,0,1,1, 1,0,1,1, 3'd1));
        tbl.push_back(v(0, 1,0,0,0,1, 0,0,0,0, 3'd1));
        tbl.push_back(v(0, 1,1,0,0,1, 1,0,1,1, 3'd0));
        tbl.push_back(v(0, 1,1,0,0,1, 1,1,0,0, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd1));
        tbl.push_back(v(0, 0,0,0,0,1, 0,0,0,0, 3'd0));

        // Reset and idle: requests and s_gnt held through reset release
        m0_if.req = 1'b1; m1_if.req = 1'b1; s_if.gnt = 1'b1;
        cyc();
        cyc();
        #1;
        chk1("rst_sreq", s_if.req, 1'b0);
        chk1("rst_m0_gnt", m0_if.gnt, 1'b0);
        chk1("rst_m1_gnt", m1_if.gnt, 1'b0);
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_saddr", s_if.addr, A0);
        chk1("rst_err", err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("rel_cycle1_sreq", s_if.req, 1'b0);
        chk1("rel_cycle1_m0_gnt", m0_if.gnt, 1'b0);
        cyc();
        #1;
        chk1("rel_cycle2_sreq", s_if.req, 1'b1);
        chk1("rel_cycle2_m0_gnt", m0_if.gnt, 1'b1);
        chk1("rel_cycle2_m1_gnt", m1_if.gnt, 1'b0);
        chk("rel_cycle2_saddr", s_if.addr, A0);
        cyc();
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        #1;
        chk("pre_flush_outst", 32'(outst), 32'd1);

        // Mid-operation reset flushes the ID; the stale response flags an error
        do_reset();
        #1;
        chk("flush_outst", 32'(outst), 32'd0);
        chk1("flush_err", err, 1'b0);
        s_if.rvalid = 1'b1; s_if.rdata = 32'hBAD0_0001;
        #1;
        chk1("stale_m0_rvalid", m0_if.rvalid, 1'b0);
        chk1("stale_m1_rvalid", m1_if.rvalid, 1'b0);
        cyc();
        s_if.rvalid = 1'b0;
        #1;
        chk1("err_set", err, 1'b1);
        chk("err_outst", 32'(outst), 32'd0);
        repeat (3) cyc();
        chk1("err_sticky", err, 1'b1);
        do_reset();
        #1;
        chk1("err_cleared", err, 1'b0);

        // Vector table with auto-responder, rvalid one cycle after each grant
        auto_resp = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                m0_if.req = 1'b0; m1_if.req = 1'b0;
                m0_if.lock = 1'b0; m1_if.lock = 1'b0;
                do_reset();
                tick();
            end
            m0_if.req  = tbl[i].m0_req;
            m1_if.req  = tbl[i].m1_req;
            m0_if.lock = tbl[i].m0_lock;
            m1_if.lock = tbl[i].m1_lock;
            s_if.gnt   = tbl[i].s_gnt;
            #1;
            chk1($sformatf("row%0d_sreq", i), s_if.req, tbl[i].e_sreq);
            chk1($sformatf("row%0d_m0_gnt", i), m0_if.gnt, tbl[i].e_g0);
            chk1($sformatf("row%0d_m1_gnt", i), m1_if.gnt, tbl[i].e_g1);
            chk($sformatf("row%0d_outst", i), 32'(outst), 32'(tbl[i].e_outst));
            if (tbl[i].e_sreq)
                chk($sformatf("row%0d_saddr", i), s_if.addr, tbl[i].e_asel ? A1 : A0);
            if (tbl[i].e_g0) sb.push_back(mk(1'b0, mem_f(A0)));
            if (tbl[i].e_g1) sb.push_back(mk(1'b1, mem_f(A1)));
            tick();
        end
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        auto_resp = 1'b0;

        // Full FIFO: four grants with no responses, then one response frees a slot
        m0_if.req = 1'b0; m1_if.req = 1'b0; m0_if.lock = 1'b0; m1_if.lock = 1'b0;
        do_reset();
        cyc();
        m0_if.req = 1'b1; m1_if.req = 1'b1; s_if.gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1($sformatf("fill%0d_m0_gnt", k), m0_if.gnt, (k % 2) == 0);
            chk1($sformatf("fill%0d_m1_gnt", k), m1_if.gnt, (k % 2) == 1);
            chk($sformatf("fill%0d_outst", k), 32'(outst), 32'(k));
            cyc();
        end
        #1;
        chk1("full_sreq", s_if.req, 1'b0);
        chk("full_outst", 32'(outst), 32'd4);
        chk1("full_m0_gnt", m0_if.gnt, 1'b0);
        s_if.rvalid = 1'b1; s_if.rdata = 32'hCAFE_0001;
        #1;
        chk1("full_pop_sreq", s_if.req, 1'b0);
        chk1("full_pop_m0_rvalid", m0_if.rvalid, 1'b1);
        chk1("full_pop_m1_rvalid", m1_if.rvalid, 1'b0);
        chk("full_pop_rdata", m0_if.rdata, 32'hCAFE_0001);
        chk("full_pop_outst", 32'(outst), 32'd4);
        cyc();
        s_if.rvalid = 1'b0;
        #1;
        chk("after_pop_outst", 32'(outst), 32'd3);
        chk1("after_pop_sreq", s_if.req, 1'b1);
        chk1("after_pop_m0_gnt", m0_if.gnt, 1'b1);
        chk1("after_pop_m1_gnt", m1_if.gnt, 1'b0);
        cyc();
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_0A00 + 32'(j);
            #1;
            chk1($sformatf("drain%0d_m1_rvalid", j), m1_if.rvalid, (j % 2) == 0);
            chk1($sformatf("drain%0d_m0_rvalid", j), m0_if.rvalid, (j % 2) == 1);
            chk($sformatf("drain%0d_rdata", j), m1_if.rdata, 32'h0000_0A00 + 32'(j));
            cyc();
        end
        s_if.rvalid = 1'b0;
        #1;
        chk("drain_outst", 32'(outst), 32'd0);
        chk1("drain_err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
